cla_addsub_pipe: RTL and testbench

CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

---
 rtl/cla_pkg.sv | 10 +
 rtl/cla_group4.sv | 24 ++
 rtl/cla_addsub_pipe.sv | 186 ++++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  function automatic int unsigned num_groups(input int unsigned width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit lookahead group: group propagate/generate and the three carries inside the group.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] p_i,
  input  logic [GROUP_W-1:0] g_i,
  input  logic               ci_i,
  output logic               gp_o,
  output logic               gg_o,
  output logic [GROUP_W-2:0] c_o
);

  assign gp_o = &p_i;
  assign gg_o = g_i[3]
              | (p_i[3] & g_i[2])
              | (p_i[3] & p_i[2] & g_i[1])
              | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);

  assign c_o[0] = g_i[0] | (p_i[0] & ci_i);
  assign c_o[1] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & ci_i);
  assign c_o[2] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & ci_i);

endmodule

// File: rtl/cla_addsub_pipe.sv
// Valid/ready pipelined add/subtract: input register, optional mid register, lookahead sum into output register.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PIPE_MID = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG = num_groups(WIDTH);

  if ((WIDTH < GROUP_W) || ((WIDTH % GROUP_W) != 0)) begin : g_bad_width
    $error("cla_addsub_pipe: WIDTH must be a multiple of 4 and at least 4");
  end

  logic             s0_v_q;
  logic [WIDTH-1:0] s0_a_q;
  logic [WIDTH-1:0] s0_b_q;
  logic             s0_c_q;
  logic [WIDTH-1:0] s0_b_d;
  logic             s0_c_d;

  logic             s1_v;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_c;
  logic             s1_ready;
  logic             s2_ready;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s0_v_q || s1_ready;

  // Subtraction is folded in here so later stages only ever add.
  assign s0_b_d = b ^ {WIDTH{sub}};
  assign s0_c_d = cin ^ sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v_q <= 1'b0;
      s0_a_q <= '0;
      s0_b_q <= '0;
      s0_c_q <= 1'b0;
    end else if (in_ready) begin
      s0_v_q <= in_valid;
      if (in_valid) begin
        s0_a_q <= a;
        s0_b_q <= s0_b_d;
        s0_c_q <= s0_c_d;
      end
    end
  end

  if (PIPE_MID != 0) begin : g_mid
    logic             v_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] g_q;
    logic             c_q;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] g_d;

    assign p_d      = s0_a_q ^ s0_b_q;
    assign g_d      = s0_a_q & s0_b_q;
    assign s1_ready = !v_q || s2_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        p_q <= '0;
        g_q <= '0;
        c_q <= 1'b0;
      end else if (s1_ready) begin
        v_q <= s0_v_q;
        if (s0_v_q) begin
          p_q <= p_d;
          g_q <= g_d;
          c_q <= s0_c_q;
        end
      end
    end

    assign s1_v = v_q;
    assign s1_p = p_q;
    assign s1_g = g_q;
    assign s1_c = c_q;
  end else begin : g_no_mid
    assign s1_ready = s2_ready;
    assign s1_v     = s0_v_q;
    assign s1_p     = s0_a_q ^ s0_b_q;
    assign s1_g     = s0_a_q & s0_b_q;
    assign s1_c     = s0_c_q;
  end

  logic [NG-1:0]              grp_p;
  logic [NG-1:0]              grp_g;
  logic [NG:0]                grp_c;
  logic [NG-1:0][GROUP_W-2:0] int_c;
  logic [WIDTH:0]             carry;
  logic                       la_acc;
  logic                       la_pand;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .p_i  (s1_p[GROUP_W*k +: GROUP_W]),
      .g_i  (s1_g[GROUP_W*k +: GROUP_W]),
      .ci_i (grp_c[k]),
      .gp_o (grp_p[k]),
      .gg_o (grp_g[k]),
      .c_o  (int_c[k])
    );
  end

  // Second-level lookahead: each group carry is its own sum of products over lower groups.
  always_comb begin
    grp_c    = '0;
    la_acc   = 1'b0;
    la_pand  = 1'b1;
    grp_c[0] = s1_c;
    for (int unsigned k = 1; k <= NG; k++) begin
      la_acc  = 1'b0;
      la_pand = 1'b1;
      for (int unsigned j = 0; j < k; j++) begin
        la_acc  = la_acc | (la_pand & grp_g[k-1-j]);
        la_pand = la_pand & grp_p[k-1-j];
      end
      grp_c[k] = la_acc | (la_pand & s1_c);
    end
  end

  always_comb begin
    carry = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      carry[GROUP_W*k] = grp_c[k];
      for (int unsigned m = 0; m < GROUP_W - 1; m++) begin
        carry[GROUP_W*k + m + 1] = int_c[k][m];
      end
    end
    carry[WIDTH] = grp_c[NG];
  end

  assign sum_d  = s1_p ^ carry[WIDTH-1:0];
  assign cout_d = carry[WIDTH];
  assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (s2_ready) begin
      out_valid_q <= s1_v;
      if (s1_v) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: 16-bit no-mid instance for directed cases, 8-bit mid instance for a random stream.
module tb_cla_addsub_pipe;

  localparam int LAT16 = 2;
  localparam int LAT8  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid16 = 1'b0, in_ready16, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        out_valid16, out_ready16 = 1'b1, cout16, ovf16;

  logic        in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        out_valid8, out_ready8 = 1'b1, cout8, ovf8;

  cla_addsub_pipe #(.WIDTH(16), .PIPE_MID(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  cla_addsub_pipe #(.WIDTH(8), .PIPE_MID(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          lat;
  } sb_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  sb_t q16[$];
  sb_t q8[$];

  int n_checks = 0;
  int n_pass   = 0;
  int pop16    = 0;
  int pop8     = 0;
  bit nrdy16   = 0;

  logic [15:0] e16_s = '0, e8_s = '0;
  logic        e16_co = 1'b0, e16_ov = 1'b0, e8_co = 1'b0, e8_ov = 1'b0;
  bit          e16_lat = 0, e8_lat = 0;

  bit bp_active = 0;
  int bp_start  = 0;
  bit rand_en8  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer add of a and the effective operand; overflow from operand/result signs.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sb);
    int unsigned mask, ua, ub, uc, tot, s, co, ov;
    mask = (32'd1 << w) - 32'd1;
    ua   = 32'(a);
    ub   = sb ? (~32'(b) & mask) : 32'(b);
    uc   = sb ? 32'(!ci) : 32'(ci);
    tot  = ua + ub + uc;
    s    = tot & mask;
    co   = (tot >> w) & 32'd1;
    ov   = ((((ua >> (w-1)) & 1) == ((ub >> (w-1)) & 1)) &&
            (((s >> (w-1)) & 1) != ((ua >> (w-1)) & 1))) ? 32'd1 : 32'd0;
    return {ov[0], co[0], s[15:0]};
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    out_ready16 = !(bp_active && (cyc - bp_start >= 3) && (cyc - bp_start <= 5));
    out_ready8  = rand_en8 ? ($urandom_range(0, 9) < 7) : 1'b1;
  end

  logic [17:0] hold16, hold8;
  bit          stall16 = 0, stall8 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall16 = 0;
    end else begin
      if (stall16) chk("stall_hold16", 32'({out_valid16, cout16, ovf16, sum16}), 32'({1'b1, hold16}));
      if (out_valid16 && out_ready16) begin
        if (q16.size() == 0) chk("spurious_out16", 32'(out_valid16), 32'(0));
        else begin
          sb_t e;
          e = q16.pop_front();
          chk("result16", 32'({cout16, ovf16, sum16}), 32'({e.cout, e.ovf, e.sum}));
          if (e.lat) chk("latency16", 32'(cyc - e.acc), 32'(LAT16));
          pop16++;
        end
      end
      if (in_valid16 && in_ready16) q16.push_back('{e16_s, e16_co, e16_ov, cyc, e16_lat});
      if (in_valid16 && !in_ready16) nrdy16 = 1;
      stall16 = out_valid16 && !out_ready16;
      hold16  = {cout16, ovf16, sum16};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall8 = 0;
    end else begin
      if (stall8) chk("stall_hold8", 32'({out_valid8, cout8, ovf8, sum8}), 32'({1'b1, hold8[9:0]}));
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) chk("spurious_out8", 32'(out_valid8), 32'(0));
        else begin
          sb_t e;
          e = q8.pop_front();
          chk("result8", 32'({cout8, ovf8, sum8}), 32'({e.cout, e.ovf, e.sum[7:0]}));
          if (e.lat) chk("latency8", 32'(cyc - e.acc), 32'(LAT8));
          pop8++;
        end
      end
      if (in_valid8 && in_ready8) q8.push_back('{e8_s, e8_co, e8_ov, cyc, e8_lat});
      stall8 = out_valid8 && !out_ready8;
      hold8  = {8'h00, cout8, ovf8, sum8};
    end
  end

  // Presents one beat and returns at the cycle after it was accepted (valid left high).
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                        input logic [17:0] exp, input bit lat);
    bit ok = 0;
    a16 = a; b16 = b; cin16 = ci; sub16 = sb; in_valid16 = 1'b1;
    {e16_ov, e16_co, e16_s} = exp; e16_lat = lat;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready16;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout16", 32'(ok), 32'(1));
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                       input bit lat);
    bit ok = 0;
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; in_valid8 = 1'b1;
    {e8_ov, e8_co, e8_s} = model(8, 16'(a), 16'(b), ci, sb); e8_lat = lat;
    for (int t = 0; t < 256 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready8;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout8", 32'(ok), 32'(1));
  endtask

  task automatic drain(input int maxc);
    for (int t = 0; t < maxc && (q16.size() != 0 || q8.size() != 0); t++) @(negedge clk);
    chk("drain_empty", 32'(q16.size() + q8.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[10];

  initial begin
    int p16_before;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst_out_valid16", 32'(out_valid16), 32'(0));
    chk("rst_outputs16", 32'({cout16, ovf16, sum16}), 32'(0));
    chk("rst_in_ready16", 32'(in_ready16), 32'(1));
    chk("rst_in_ready8", 32'(in_ready8), 32'(1));
    chk("rst_out_valid8", 32'(out_valid8), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: first vector alone for latency, the rest back-to-back
    send16(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, {vecs[0].ov, vecs[0].co, vecs[0].s}, 1);
    in_valid16 = 1'b0;
    drain(20);
    for (int i = 1; i < 10; i++)
      send16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, {vecs[i].ov, vecs[i].co, vecs[i].s}, 0);
    in_valid16 = 1'b0;
    drain(40);

    // Backpressure: six beats, consumer stalls in relative cycles 3-5
    nrdy16 = 0;
    p16_before = pop16;
    bp_start = cyc;
    bp_active = 1;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'(i % 2);
      send16(ra, rb, rc, rs, model(16, ra, rb, rc, rs), 0);
    end
    in_valid16 = 1'b0;
    drain(40);
    bp_active = 0;
    chk("bp_in_ready_dropped", 32'(nrdy16), 32'(1));
    chk("bp_beats_out", 32'(pop16 - p16_before), 32'(6));

    // Reset with two beats in flight
    send16(16'h1111, 16'h2222, 1'b0, 1'b0, model(16, 16'h1111, 16'h2222, 1'b0, 1'b0), 0);
    send16(16'h0F0F, 16'h0101, 1'b0, 1'b1, model(16, 16'h0F0F, 16'h0101, 1'b0, 1'b1), 0);
    in_valid16 = 1'b0;
    #1;
    chk("inflight_before_reset", 32'(out_valid16), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid16", 32'(out_valid16), 32'(0));
    chk("midrst_outputs16", 32'({cout16, ovf16, sum16}), 32'(0));
    chk("midrst_in_ready16", 32'(in_ready16), 32'(1));
    q16.delete();
    a16 = 16'hAAAA; b16 = 16'h5555; in_valid16 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    in_valid16 = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_ghost_after_reset", 32'(out_valid16), 32'(0));
    send16(16'h0003, 16'h0004, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0007}, 1);
    in_valid16 = 1'b0;
    drain(20);

    // 8-bit mid-register instance: isolated beat, then random stream with random consumer
    send8(8'h7F, 8'h01, 1'b0, 1'b0, 1);
    in_valid8 = 1'b0;
    drain(20);
    p16_before = pop8;
    rand_en8 = 1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid8 = 1'b0;
        @(posedge clk); #1;
      end
      send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);
    end
    in_valid8 = 1'b0;
    rand_en8 = 0;
    drain(400);
    chk("rand_beats_out8", 32'(pop8 - p16_before), 32'(200));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
